// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg: slot record, constants and select-width helper. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

  // Widest register index the slot record can carry; narrower indices are zero-extended.
  localparam int REG_W_MAX   = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] dst;
    logic                 reg_write;
    logic                 mem_read;
  } slot_t;

  function automatic int sel_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_src_match.sv
// ---------------------------------------------------------------------------
// hazard_src_match: one source operand vs all in-flight slots -> {select, load hazard}. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_READY = 3,
  parameter int SEL_W      = 2
) (
  input  slot_t [NUM_STAGES-1:0] slots_i,
  input  logic  [REG_W-1:0]      src_i,
  input  logic                   used_i,
  input  logic                   id_valid_i,
  output logic  [SEL_W-1:0]      sel_o,
  output logic                   load_hazard_o
);

  // Walk oldest to youngest so the youngest matching producer has the final say.
  always_comb begin
    sel_o         = SEL_W'(FWD_REGFILE);
    load_hazard_o = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (id_valid_i && used_i && slots_i[k-1].valid && slots_i[k-1].reg_write &&
          (slots_i[k-1].dst != '0) && (slots_i[k-1].dst == REG_W_MAX'(src_i))) begin
        sel_o         = (k + 1 > NUM_STAGES) ? SEL_W'(FWD_REGFILE) : SEL_W'(k + 1);
        load_hazard_o = slots_i[k-1].mem_read && (k + 1 < LOAD_READY);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl: forwarding select + load-use interlock; HAZARD_FWD_STATS_EN adds counters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_READY = 3,
  parameter int SEL_W      = sel_width(NUM_STAGES)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       id_valid_i,
  input  logic [NUM_SRC*REG_W-1:0]   id_src_i,
  input  logic [NUM_SRC-1:0]         id_src_used_i,
  input  logic [REG_W-1:0]           id_dst_i,
  input  logic                       id_reg_write_i,
  input  logic                       id_mem_read_i,
  input  logic                       flush_i,
  input  logic                       freeze_i,
  output logic                       stall_o,
  output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel_o
`ifdef HAZARD_FWD_STATS_EN
  ,
  output logic [31:0]                stat_stall_o,
  output logic [31:0]                stat_fwd_o,
  output logic [31:0]                stat_flush_o
`endif
);

  // Index 0 is slot 1 (EX); index NUM_STAGES-1 is the oldest tracked slot.
  slot_t [NUM_STAGES-1:0]     slots_q, slots_d;
  slot_t                      new_slot;
  logic [NUM_SRC*SEL_W-1:0]   sel_q, sel_d, dec_sel;
  logic [NUM_SRC-1:0]         load_haz;
  logic                       hazard;
  logic                       bubble;

  generate
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      hazard_src_match #(
        .REG_W      (REG_W),
        .NUM_STAGES (NUM_STAGES),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W)
      ) u_match (
        .slots_i       (slots_q),
        .src_i         (id_src_i[s*REG_W +: REG_W]),
        .used_i        (id_src_used_i[s]),
        .id_valid_i    (id_valid_i),
        .sel_o         (dec_sel[s*SEL_W +: SEL_W]),
        .load_hazard_o (load_haz[s])
      );
    end
  endgenerate

  assign hazard  = |load_haz;
  assign bubble  = flush_i | hazard;
  // A flushed instruction is dead and a frozen pipe cannot move, so neither may stall.
  assign stall_o = hazard & ~flush_i & ~freeze_i;

  always_comb begin
    new_slot = '0;
    if (!bubble) begin
      new_slot.valid     = id_valid_i;
      new_slot.dst       = REG_W_MAX'(id_dst_i);
      new_slot.reg_write = id_reg_write_i;
      new_slot.mem_read  = id_mem_read_i;
    end
  end

  always_comb begin
    slots_d = slots_q;
    sel_d   = sel_q;
    if (!freeze_i) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        slots_d[k] = slots_q[k-1];
      end
      slots_d[0] = new_slot;
      sel_d      = bubble ? '0 : dec_sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slots_q <= '0;
      sel_q   <= '0;
    end else begin
      slots_q <= slots_d;
      sel_q   <= sel_d;
    end
  end

  assign ex_fwd_sel_o = sel_q;

`ifdef HAZARD_FWD_STATS_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q, flush_cnt_q;
  logic [31:0] fwd_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

  always_comb begin
    fwd_inc = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (dec_sel[s*SEL_W +: SEL_W] != '0) fwd_inc = fwd_inc + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else if (!freeze_i) begin
      stall_cnt_q <= sat_add(stall_cnt_q, {31'd0, stall_o});
      flush_cnt_q <= sat_add(flush_cnt_q, {31'd0, flush_i});
      if (!bubble) fwd_cnt_q <= sat_add(fwd_cnt_q, fwd_inc);
    end
  end

  assign stat_stall_o = stall_cnt_q;
  assign stat_fwd_o   = fwd_cnt_q;
  assign stat_flush_o = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_ctrl: two configurations (3 slots/LOAD_READY 3, 4 slots/LOAD_READY 4) vs a history model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_fwd_ctrl;

  localparam int RW  = 5;
  localparam int NS  = 2;
  localparam int NSA = 3;
  localparam int LRA = 3;
  localparam int NSB = 4;
  localparam int LRB = 4;
  localparam int SWA = $clog2(NSA + 1);
  localparam int SWB = $clog2(NSB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, id_valid, id_reg_write, id_mem_read, flush, freeze;
  logic [NS*RW-1:0]  id_src;
  logic [NS-1:0]     used;
  logic [RW-1:0]     id_dst;
  logic              stall_a, stall_b;
  logic [NS*SWA-1:0] sel_a;
  logic [NS*SWB-1:0] sel_b;
`ifdef HAZARD_FWD_STATS_EN
  logic [31:0] st_stall_a, st_fwd_a, st_flush_a, st_stall_b, st_fwd_b, st_flush_b;
`endif

  hazard_fwd_ctrl #(.REG_W(RW), .NUM_SRC(NS), .NUM_STAGES(NSA), .LOAD_READY(LRA)) dut_a (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_src_i(id_src), .id_src_used_i(used),
    .id_dst_i(id_dst), .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
    .flush_i(flush), .freeze_i(freeze), .stall_o(stall_a), .ex_fwd_sel_o(sel_a)
`ifdef HAZARD_FWD_STATS_EN
    , .stat_stall_o(st_stall_a), .stat_fwd_o(st_fwd_a), .stat_flush_o(st_flush_a)
`endif
  );

  hazard_fwd_ctrl #(.REG_W(RW), .NUM_SRC(NS), .NUM_STAGES(NSB), .LOAD_READY(LRB)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_src_i(id_src), .id_src_used_i(used),
    .id_dst_i(id_dst), .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
    .flush_i(flush), .freeze_i(freeze), .stall_o(stall_b), .ex_fwd_sel_o(sel_b)
`ifdef HAZARD_FWD_STATS_EN
    , .stat_stall_o(st_stall_b), .stat_fwd_o(st_fwd_b), .stat_flush_o(st_flush_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: the instructions issued into each pipe, indexed by age (1 = just issued).
  typedef struct {
    bit v;
    int dst;
    bit rw;
    bit mr;
  } ins_t;

  ins_t pipe    [2][1:8];
  int   exp_sel [2][NS];
  int   dec_sel [2][NS];
  bit   dec_haz [2];
  int   nst     [2] = '{NSA, NSB};
  int   lrd     [2] = '{LRA, LRB};
  int   exp_st_stall, exp_st_fwd, exp_st_flush;
  bit   chk_en = 1'b0;
  bit   last_stall_a, last_stall_b;

  function automatic void model_decode(input int d);
    int src;
    dec_haz[d] = 1'b0;
    for (int s = 0; s < NS; s++) begin
      dec_sel[d][s] = 0;
      src = int'(id_src[s*RW +: RW]);
      if (id_valid && used[s] && src != 0) begin
        for (int age = 1; age <= nst[d]; age++) begin
          if (pipe[d][age].v && pipe[d][age].rw && pipe[d][age].dst == src) begin
            // By the time the consumer is in EX the producer has aged by one.
            dec_sel[d][s] = (age + 1 <= nst[d]) ? age + 1 : 0;
            if (pipe[d][age].mr && (age + 1 < lrd[d])) dec_haz[d] = 1'b1;
            break;
          end
        end
      end
    end
  endfunction

  function automatic void model_advance(input int d);
    bit dead;
    if (rst) begin
      for (int a = 1; a <= 8; a++) pipe[d][a] = '{v: 1'b0, dst: 0, rw: 1'b0, mr: 1'b0};
      for (int s = 0; s < NS; s++) exp_sel[d][s] = 0;
    end else if (!freeze) begin
      dead = flush || dec_haz[d];
      for (int a = nst[d]; a >= 2; a--) pipe[d][a] = pipe[d][a-1];
      if (dead) pipe[d][1] = '{v: 1'b0, dst: 0, rw: 1'b0, mr: 1'b0};
      else      pipe[d][1] = '{v: id_valid, dst: int'(id_dst), rw: id_reg_write, mr: id_mem_read};
      for (int s = 0; s < NS; s++) exp_sel[d][s] = dead ? 0 : dec_sel[d][s];
    end
  endfunction

  task automatic step(input bit v, input logic [NS*RW-1:0] src, input logic [NS-1:0] u,
                      input logic [RW-1:0] dst, input bit rw, input bit mr,
                      input bit fl, input bit fz, input bit rs);
    @(negedge clk);
    id_valid = v; id_src = src; used = u; id_dst = dst;
    id_reg_write = rw; id_mem_read = mr; flush = fl; freeze = fz; rst = rs;
    #1;
    model_decode(0);
    model_decode(1);
    last_stall_a = stall_a;
    last_stall_b = stall_b;
    if (chk_en) begin
      for (int s = 0; s < NS; s++) begin
        check_eq($sformatf("sel_a%0d", s), 64'(sel_a[s*SWA +: SWA]), 64'(exp_sel[0][s]));
        check_eq($sformatf("sel_b%0d", s), 64'(sel_b[s*SWB +: SWB]), 64'(exp_sel[1][s]));
      end
`ifdef HAZARD_FWD_STATS_EN
      check_eq("stat_stall_a", 64'(st_stall_a), 64'(exp_st_stall));
      check_eq("stat_fwd_a",   64'(st_fwd_a),   64'(exp_st_fwd));
      check_eq("stat_flush_a", 64'(st_flush_a), 64'(exp_st_flush));
`endif
      if (!rs) begin
        check_eq("stall_a", 64'(stall_a), 64'(dec_haz[0] && !fl && !fz));
        check_eq("stall_b", 64'(stall_b), 64'(dec_haz[1] && !fl && !fz));
      end
    end
    @(posedge clk);
    if (rs) begin
      exp_st_stall = 0; exp_st_fwd = 0; exp_st_flush = 0;
    end else if (!fz) begin
      exp_st_stall += int'(dec_haz[0] && !fl);
      exp_st_flush += int'(fl);
      if (!(fl || dec_haz[0]))
        for (int s = 0; s < NS; s++) exp_st_fwd += int'(dec_sel[0][s] != 0);
    end
    model_advance(0);
    model_advance(1);
  endtask

  function automatic logic [NS*RW-1:0] srcs(input int a, input int b);
    logic [RW-1:0] ra, rb;
    ra = RW'(a);
    rb = RW'(b);
    return {rb, ra};
  endfunction

  // Shorthands: issue an ALU write, a load, or a consumer reading (a, b).
  task automatic alu(input int d, input int a, input int b);
    step(1'b1, srcs(a, b), 2'b11, RW'(d), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic load(input int d, input int a);
    step(1'b1, srcs(a, 0), 2'b01, RW'(d), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic nop();
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int cnt_a, cnt_b;

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_src = '0; used = '0; id_dst = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0; freeze = 1'b0;
    exp_st_stall = 0; exp_st_fwd = 0; exp_st_flush = 0;
    for (int d = 0; d < 2; d++) begin
      for (int a = 1; a <= 8; a++) pipe[d][a] = '{v: 1'b0, dst: 0, rw: 1'b0, mr: 1'b0};
      for (int s = 0; s < NS; s++) exp_sel[d][s] = 0;
    end
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    #1;
    check_eq("rst_sel_a", 64'(sel_a), 64'd0);
    check_eq("rst_sel_b", 64'(sel_b), 64'd0);
    check_eq("rst_stall", 64'(stall_a | stall_b), 64'd0);

    // Back-to-back dependency: producer sits in slot 1, lands in slot 2 during EX.
    alu(3, 1, 2);
    alu(6, 3, 1);
    check_eq("t1_stall", 64'(last_stall_a | last_stall_b), 64'd0);
    #1;
    check_eq("t1_sel_a", 64'(sel_a[SWA-1:0]), 64'd2);
    check_eq("t1_sel_b", 64'(sel_b[SWB-1:0]), 64'd2);

    // One gap -> slot 3; two gaps -> beyond the 3-slot window, still tracked by the 4-slot one.
    alu(9, 0, 0);
    nop();
    alu(1, 0, 9);
    #1;
    check_eq("t2_gap1_a", 64'(sel_a[2*SWA-1:SWA]), 64'd3);
    check_eq("t2_gap1_b", 64'(sel_b[2*SWB-1:SWB]), 64'd3);
    alu(10, 0, 0);
    nop();
    nop();
    alu(1, 10, 0);
    #1;
    check_eq("t2_gap2_a", 64'(sel_a[SWA-1:0]), 64'd0);
    check_eq("t2_gap2_b", 64'(sel_b[SWB-1:0]), 64'd4);

    // Load-use: consumer held in ID; count stall cycles per configuration.
    load(4, 1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, srcs(4, 0), 2'b01, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cnt_a += int'(last_stall_a);
      cnt_b += int'(last_stall_b);
    end
    check_eq("t3_stalls_a", 64'(cnt_a), 64'd1);
    check_eq("t3_stalls_b", 64'(cnt_b), 64'd2);

    // Register 0 never matches, even from a load; younger of two producers wins.
    load(0, 1);
    step(1'b1, srcs(0, 0), 2'b11, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t4_r0_stall", 64'(last_stall_a | last_stall_b), 64'd0);
    #1;
    check_eq("t4_r0_sel", 64'(sel_a), 64'd0);
    alu(5, 0, 0);
    alu(5, 0, 0);
    alu(1, 5, 0);
    #1;
    check_eq("t4_young_a", 64'(sel_a[SWA-1:0]), 64'd2);

    // Flush overrides a load-use hazard; freeze holds the select register.
    load(4, 1);
    step(1'b1, srcs(4, 0), 2'b01, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t5_flush_stall", 64'(last_stall_a | last_stall_b), 64'd0);
    alu(11, 0, 0);
    alu(1, 11, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, srcs(1, 1), 2'b11, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      check_eq("t5_freeze_sel", 64'(sel_a[SWA-1:0]), 64'd2);
    end

    // Reset during a load-use stall.
    load(12, 0);
    step(1'b1, srcs(12, 0), 2'b01, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t6_pre_stall", 64'(last_stall_a), 64'd1);
    step(1'b1, srcs(12, 0), 2'b01, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("t6_stall", 64'(stall_a | stall_b), 64'd0);
    check_eq("t6_sel", 64'(sel_a | NS*SWA'(sel_b)), 64'd0);
`ifdef HAZARD_FWD_STATS_EN
    check_eq("t6_stats", 64'(st_stall_a | st_fwd_a | st_flush_a), 64'd0);
`endif

    // Random traffic over a small register set to provoke frequent matches.
    for (int i = 0; i < 3000; i++) begin
      bit rw;
      rw = 1'($urandom_range(0, 1));
      step($urandom_range(0, 9) != 0,
           srcs($urandom_range(0, 7), $urandom_range(0, 7)),
           NS'($urandom_range(0, 3)),
           RW'($urandom_range(0, 7)),
           rw, rw && ($urandom_range(0, 2) == 0),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
